des_cbc_mode_ctrl: RTL

Block-mode front end placed directly upstream of the DES core. It accepts 64-bit blocks over a valid/ready stream and applies ECB or CBC chaining. It drives the core's encipher/decipher enables, data and key, waits for the core's ready indication, and returns results on an output valid/ready stream. It also owns the IV/chain register and a watchdog on the core.

---
 rtl/des_cbc_mode_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/des_cbc_mode_ctrl.sv
// ============================================================================
// des_cbc_mode_ctrl : ECB/CBC block-mode front end and watchdog for a DES core
// Rev 1.0
// ============================================================================
`default_nettype none

module des_cbc_mode_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int START_HOLDOFF  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_cbc,
  input  logic        cfg_decrypt,
  input  logic [63:0] cfg_key,
  input  logic        iv_load,
  input  logic [63:0] iv_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        core_encipher_en,
  output logic        core_decipher_en,
  output logic [63:0] core_data,
  output logic [63:0] core_key,
  input  logic        core_ready,
  input  logic [63:0] core_result,
  output logic        busy,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_HOLDOFF      = CW'(START_HOLDOFF);
  localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic          r_cbc, r_dec, r_in_ready, r_enc_en, r_dec_en, r_err;
  logic [63:0]   r_blk, r_chain, r_core_data, r_core_key, r_out_data;
  logic [CW-1:0] r_cnt;

  logic          w_accept, w_iv_load, w_core_hit, w_timeout;
  logic [63:0]   w_chain_eff;

  assign w_accept    = (r_state == S_IDLE) && r_in_ready && in_valid;
  assign w_iv_load   = (r_state == S_IDLE) && iv_load;
  // A same-cycle IV load takes effect for the block being accepted.
  assign w_chain_eff = w_iv_load ? iv_in : r_chain;
  assign w_core_hit  = (r_state == S_WAIT) && core_ready && (r_cnt >= C_HOLDOFF);
  assign w_timeout   = (r_state == S_WAIT) && !w_core_hit && (r_cnt == C_TIMEOUT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_core_hit)     w_state_nxt = S_OUTPUT;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_OUTPUT: if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_enc_en    <= 1'b0;
      r_dec_en    <= 1'b0;
      r_err       <= 1'b0;
      r_cbc       <= 1'b0;
      r_dec       <= 1'b0;
      r_blk       <= '0;
      r_chain     <= '0;
      r_core_data <= '0;
      r_core_key  <= '0;
      r_out_data  <= '0;
      r_cnt       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // in_ready is registered so it stays low through the handshake cycle.
      r_in_ready <= (w_state_nxt == S_IDLE);
      r_enc_en   <= w_accept && !cfg_decrypt;
      r_dec_en   <= w_accept && cfg_decrypt;

      if (w_iv_load) begin
        r_chain <= iv_in;
        r_err   <= 1'b0;
      end

      if (w_accept) begin
        r_blk       <= in_data;
        r_cbc       <= cfg_cbc;
        r_dec       <= cfg_decrypt;
        r_core_key  <= cfg_key;
        r_core_data <= (cfg_cbc && !cfg_decrypt) ? (in_data ^ w_chain_eff) : in_data;
      end

      if (r_state == S_ISSUE) r_cnt <= '0;
      if (r_state == S_WAIT)  r_cnt <= r_cnt + CW'(1);

      if (w_core_hit) begin
        if (r_dec && r_cbc) begin
          r_out_data <= core_result ^ r_chain;
          r_chain    <= r_blk;
        end else begin
          r_out_data <= core_result;
          if (r_cbc) r_chain <= core_result;
        end
      end

      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign in_ready         = r_in_ready;
  assign out_valid        = (r_state == S_OUTPUT);
  assign out_data         = r_out_data;
  assign core_encipher_en = r_enc_en;
  assign core_decipher_en = r_dec_en;
  assign core_data        = r_core_data;
  assign core_key         = r_core_key;
  assign busy             = (r_state != S_IDLE);
  assign err_timeout      = r_err;

endmodule

`default_nettype wire
